// File: rtl/uncached_wbuf_ctrl.sv
// Uncached access path: posted-store FIFO write buffer plus a single-outstanding
// SRAM-like bus master; loads issue only once the buffer and bus are idle.
module uncached_wbuf_ctrl #(
    parameter int WB_DEPTH = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    input  logic                  req_wr,
    input  logic [1:0]            req_size,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W/8-1:0]   req_wstrb,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  wb_empty,
    output logic                  bus_req,
    output logic                  bus_wr,
    output logic [1:0]            bus_size,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W/8-1:0]   bus_wstrb,
    output logic [DATA_W-1:0]     bus_wdata,
    input  logic                  bus_addr_ok,
    input  logic                  bus_data_ok,
    input  logic [DATA_W-1:0]     bus_rdata
);

    localparam int PTR_W  = $clog2(WB_DEPTH);
    localparam int STRB_W = DATA_W / 8;
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(WB_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_RD_ADDR,
        S_RD_DATA
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [ADDR_W-1:0] r_fifo_addr  [WB_DEPTH];
    logic [1:0]        r_fifo_size  [WB_DEPTH];
    logic [STRB_W-1:0] r_fifo_wstrb [WB_DEPTH];
    logic [DATA_W-1:0] r_fifo_wdata [WB_DEPTH];

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic [ADDR_W-1:0] r_ld_addr;
    logic [1:0]        r_ld_size;

    logic w_push;
    logic w_pop;
    logic w_ld_accept;

    // Loads need a fully drained buffer and an idle bus to keep MMIO ordering strict.
    always_comb begin
        req_ready = 1'b0;
        if (resetn) begin
            if (req_wr)
                req_ready = (r_count != CNT_FULL);
            else
                req_ready = (r_count == '0) && (r_state == S_IDLE);
        end
    end

    assign w_push      = req_valid && req_ready && req_wr;
    assign w_ld_accept = req_valid && req_ready && !req_wr;
    assign wb_empty    = (r_count == '0) && (r_state != S_WR_ADDR) && (r_state != S_WR_DATA);

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        bus_req     = 1'b0;
        bus_wr      = 1'b0;
        bus_size    = '0;
        bus_addr    = '0;
        bus_wstrb   = '0;
        bus_wdata   = '0;
        resp_valid  = 1'b0;
        resp_rdata  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_ld_accept)
                    w_state_nxt = S_RD_ADDR;
                else if (r_count != '0)
                    w_state_nxt = S_WR_ADDR;
            end
            S_WR_ADDR: begin
                bus_req   = 1'b1;
                bus_wr    = 1'b1;
                bus_size  = r_fifo_size[r_rd_ptr];
                bus_addr  = r_fifo_addr[r_rd_ptr];
                bus_wstrb = r_fifo_wstrb[r_rd_ptr];
                bus_wdata = r_fifo_wdata[r_rd_ptr];
                if (bus_addr_ok) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_WR_DATA;
                end
            end
            S_WR_DATA: begin
                if (bus_data_ok)
                    w_state_nxt = (r_count != '0) ? S_WR_ADDR : S_IDLE;
            end
            S_RD_ADDR: begin
                bus_req  = 1'b1;
                bus_size = r_ld_size;
                bus_addr = r_ld_addr;
                if (bus_addr_ok)
                    w_state_nxt = S_RD_DATA;
            end
            S_RD_DATA: begin
                if (bus_data_ok) begin
                    resp_valid  = 1'b1;
                    resp_rdata  = bus_rdata;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ld_addr <= '0;
            r_ld_size <= '0;
        end else if (w_ld_accept) begin
            r_ld_addr <= req_addr;
            r_ld_size <= req_size;
        end
    end

    // Payload storage needs no reset: entries are only read once counted as valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr]  <= req_addr;
            r_fifo_size[r_wr_ptr]  <= req_size;
            r_fifo_wstrb[r_wr_ptr] <= req_wstrb;
            r_fifo_wdata[r_wr_ptr] <= req_wdata;
        end
    end

endmodule

// File: tb/tb_uncached_wbuf_ctrl.sv
// Scoreboard bench for uncached_wbuf_ctrl: expected bus transactions queued on accept,
// a negedge monitor checks bus order, handshakes, read responses and buffer status.
module tb_uncached_wbuf_ctrl;

    localparam int WB_DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid, req_wr;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata;
    logic        req_ready, resp_valid, wb_empty;
    logic [31:0] resp_rdata;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wstrb;
    logic        bus_addr_ok, bus_data_ok;

    uncached_wbuf_ctrl #(.WB_DEPTH(WB_DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_wr(req_wr), .req_size(req_size), .req_addr(req_addr),
        .req_wstrb(req_wstrb), .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .wb_empty(wb_empty),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } txn_t;

    txn_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Bus-side model state (owned by the monitor, read by the slave)
    bit          pend = 0;
    bit          pend_rd = 0;
    bit          prev_hold = 0;
    logic [71:0] prev_bus;
    logic [31:0] last_rdata = '0;
    int          n_resp = 0;

    // Slave knobs (owned by the main process)
    bit          addr_en = 1'b1;
    int          addr_pct = 100;
    int          data_pct = 100;
    bit          noise = 1'b0;
    bit          use_fixed = 1'b0;
    logic [31:0] fixed_rdata = '0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bus slave: acknowledges the address phase, then the data phase, at random delays.
    always begin
        @(posedge clk);
        #2;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        if (resetn) begin
            if (pend) begin
                if ($urandom_range(0, 99) < data_pct) begin
                    bus_data_ok = 1'b1;
                    bus_rdata   = use_fixed ? fixed_rdata : $urandom;
                end
            end else if (bus_req) begin
                if (addr_en && ($urandom_range(0, 99) < addr_pct))
                    bus_addr_ok = 1'b1;
            end else if (noise && ($urandom_range(0, 7) == 0)) begin
                bus_addr_ok = 1'b1;
                bus_data_ok = 1'b1;
            end
        end
    end

    // Monitor / scoreboard
    int   m_nwr;
    bit   m_exp_rdy, m_exp_empty, m_data_hs;
    txn_t m_t;
    always @(negedge clk) begin
        if (!resetn) begin
            exp_q.delete();
            pend      = 1'b0;
            prev_hold = 1'b0;
        end else begin
            m_nwr = 0;
            foreach (exp_q[i]) if (exp_q[i].wr) m_nwr++;
            if (req_valid) begin
                m_exp_rdy = req_wr ? (exp_q.size() != WB_DEPTH) : (exp_q.size() == 0 && !pend);
                chk(req_wr ? "req_ready_store" : "req_ready_load", req_ready, m_exp_rdy);
            end
            m_exp_empty = (m_nwr == 0) && !(pend && !pend_rd);
            chk("wb_empty", wb_empty, m_exp_empty);
            if (prev_hold)
                chk("bus_stable", {bus_req, bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata}, prev_bus);
            m_data_hs = pend && bus_data_ok;
            if (m_data_hs && pend_rd) begin
                chk("resp_valid", resp_valid, 1'b1);
                chk("resp_rdata", resp_rdata, bus_rdata);
                last_rdata = resp_rdata;
                n_resp++;
            end else begin
                chk("resp_valid_quiet", resp_valid, 1'b0);
            end
            if (m_data_hs) pend = 1'b0;
            if (bus_req && bus_addr_ok) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL bus_unexpected: got bus_req addr %h, required no transaction", bus_addr);
                end else begin
                    m_t = exp_q.pop_front();
                    chk("bus_txn",
                        {bus_wr, bus_size, bus_addr, bus_wstrb, bus_wr ? bus_wdata : 32'h0},
                        {m_t.wr, m_t.size, m_t.addr, m_t.wstrb, m_t.wr ? m_t.wdata : 32'h0});
                end
                pend      = 1'b1;
                pend_rd   = !bus_wr;
                prev_hold = 1'b0;
            end else begin
                prev_hold = bus_req;
                prev_bus  = {bus_req, bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata};
            end
            if (req_valid && req_ready)
                exp_q.push_back('{wr: req_wr, size: req_size, addr: req_addr,
                                  wstrb: req_wr ? req_wstrb : 4'h0, wdata: req_wdata});
        end
    end

    // Present one request and hold it until accepted; called at posedge+1.
    task automatic issue(input bit wr, input logic [1:0] sz, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] d);
        bit acc = 1'b0;
        int n = 0;
        req_valid = 1'b1; req_wr = wr; req_size = sz;
        req_addr = a; req_wstrb = s; req_wdata = d;
        while (!acc && n < 2000) begin
            @(negedge clk);
            acc = req_ready;
            tick();
            n++;
        end
        req_valid = 1'b0;
        if (!acc) begin
            n_chk++;
            n_fail++;
            $display("FAIL issue_timeout: got no accept for addr %h, required accept", a);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(exp_q.size() == 0 && !pend) && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d outstanding, required 0", exp_q.size());
        end
        @(negedge clk);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, required $finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "watchdog");
    end

    logic [1:0]  r_sz;
    logic [31:0] r_a;
    bit          r_wr;
    initial begin
        resetn = 1'b0; req_valid = 1'b0; req_wr = 1'b1; req_size = '0;
        req_addr = '0; req_wstrb = '0; req_wdata = '0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
        repeat (3) @(negedge clk);
        req_valid = 1'b1;
        #1;
        chk("rst_bus_req", bus_req, 1'b0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_wb_empty", wb_empty, 1'b1);
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_bus_out", {bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata}, 72'h0);
        req_valid = 1'b0;
        tick();
        resetn = 1'b1;
        tick();

        // Reset while a write address phase is stalled
        addr_en = 1'b0;
        issue(1'b1, 2'd2, 32'h1FD0_0100, 4'hF, 32'hCAFE_0001);
        tick();
        @(negedge clk);
        chk("t1_bus_req_pre", bus_req, 1'b1);
        #2;
        resetn = 1'b0; req_valid = 1'b1; req_wr = 1'b1;
        #1;
        chk("t1_bus_req", bus_req, 1'b0);
        chk("t1_wb_empty", wb_empty, 1'b1);
        chk("t1_req_ready", req_ready, 1'b0);
        req_valid = 1'b0;
        tick();
        tick();
        resetn = 1'b1; req_wr = 1'b0;
        #1;
        chk("t1_idle_load_ready", req_ready, 1'b1);
        chk("t1_wb_empty_after", wb_empty, 1'b1);
        tick();

        // Fill the buffer while the bus stalls, then release it
        addr_en = 1'b0;
        for (int i = 0; i < 4; i++)
            issue(1'b1, 2'd2, 32'h1FD0_F000 + 32'(i * 4), 4'hF, 32'hA000_0000 + 32'(i));
        req_valid = 1'b1; req_wr = 1'b1; req_size = 2'd2;
        req_addr = 32'h1FD0_F010; req_wstrb = 4'hF; req_wdata = 32'hA000_0004;
        repeat (3) begin
            @(negedge clk);
            chk("t2_full_ready", req_ready, 1'b0);
        end
        tick();
        addr_en = 1'b1; addr_pct = 100; data_pct = 100;
        issue(1'b1, 2'd2, 32'h1FD0_F010, 4'hF, 32'hA000_0004);
        wait_idle();

        // Load behind a buffered store
        data_pct = 30;
        issue(1'b1, 2'd2, 32'h1FAF_0000, 4'hF, 32'h1234_5678);
        issue(1'b0, 2'd2, 32'h1FAF_0004, 4'h0, 32'h0);
        wait_idle();

        // Load with known read data
        use_fixed = 1'b1; fixed_rdata = 32'hDEAD_BEEF; data_pct = 100;
        n_resp = 0;
        issue(1'b0, 2'd2, 32'h1FC0_0000, 4'h0, 32'h0);
        wait_idle();
        use_fixed = 1'b0;
        chk("t4_resp_count", n_resp, 1);
        chk("t4_rdata", last_rdata, 32'hDEAD_BEEF);
        req_wr = 1'b0;
        #1;
        chk("t4_load_ready", req_ready, 1'b1);

        // Ten byte stores, pointers wrap twice
        for (int i = 0; i < 10; i++)
            issue(1'b1, 2'd0, 32'h1FD0_2000 + 32'(i), 4'b0001, 32'($urandom));
        wait_idle();
        chk("t5_wb_empty", wb_empty, 1'b1);

        // Enqueue in the same cycle as a head pop at DEPTH-1
        addr_en = 1'b0;
        for (int i = 0; i < 3; i++)
            issue(1'b1, 2'd2, 32'h1FD0_3000 + 32'(i * 4), 4'hF, 32'hB000_0000 + 32'(i));
        tick();
        addr_en = 1'b1;
        issue(1'b1, 2'd2, 32'h1FD0_300C, 4'hF, 32'hB000_0003);
        addr_en = 1'b0;
        issue(1'b1, 2'd2, 32'h1FD0_3010, 4'hF, 32'hB000_0004);
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h1FD0_3014;
        @(negedge clk);
        chk("t6_full_ready", req_ready, 1'b0);
        tick();
        req_valid = 1'b0;
        addr_en = 1'b1;
        wait_idle();

        // Randomised traffic with bus noise
        noise = 1'b1;
        for (int k = 0; k < 80; k++) begin
            addr_pct = $urandom_range(20, 100);
            data_pct = $urandom_range(20, 100);
            r_wr = ($urandom_range(0, 2) != 0);
            r_sz = 2'($urandom_range(0, 2));
            r_a  = {16'h1FD0, 16'($urandom)};
            if (r_sz == 2'd1) r_a[0] = 1'b0;
            if (r_sz == 2'd2) r_a[1:0] = 2'b00;
            issue(r_wr, r_sz, r_a, r_wr ? 4'($urandom_range(1, 15)) : 4'h0, $urandom);
            repeat ($urandom_range(0, 2)) tick();
        end
        wait_idle();
        noise = 1'b0;
        chk("end_wb_empty", wb_empty, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
